// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control slice.
//  - hc_state_e  : sequencer state (RUN / FLUSH / DRAIN), explicit 2-bit encoding
//                  so older code that compares against raw constants still matches
//  - HC_*        : default register-file geometry and flush counter width
//  - onehot()    : register address to one-hot register mask
package pipeline_ctrl_pkg;

  localparam int HC_NUM_REGS   = 32;
  localparam int HC_REG_ADDR_W = 5;
  // Wide enough for FLUSH_CYCLES-1 with FLUSH_CYCLES up to 7.
  localparam int HC_FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    HC_RUN   = 2'd0,
    HC_FLUSH = 2'd1,
    HC_DRAIN = 2'd2
  } hc_state_e;

  function automatic logic [HC_NUM_REGS-1:0] onehot(input logic [HC_REG_ADDR_W-1:0] addr);
    logic [HC_NUM_REGS-1:0] mask;
    mask = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard.
//  clk, reset_n      clock, asynchronous active-low reset
//  set_en, set_addr  mark a register as having a write in flight (x0 ignored)
//  clr_en, clr_addr  writeback retires a register write this cycle
//  busy              registered pending-write vector, bit i = xi pending
//  busy_eff          busy with this cycle's writeback already removed; the
//                    register file is write-before-read, so a same-cycle
//                    writeback no longer blocks a reader
module reg_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_REGS   = HC_NUM_REGS,
  parameter int REG_ADDR_W = HC_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  output logic [NUM_REGS-1:0]   busy,
  output logic [NUM_REGS-1:0]   busy_eff
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr_en) begin
      clr_mask[clr_addr] = 1'b1;
    end
    if (set_en && (set_addr != '0)) begin
      set_mask[set_addr] = 1'b1;
    end
    busy_eff    = busy_q & ~clr_mask;
    // x0 is hard-wired zero and never pending.
    busy_eff[0] = 1'b0;
    // Applying the set after the clear makes a same-register set win.
    busy_d      = busy_eff | set_mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer beside the decode stage.
//  Inputs : ID slot description (valid, rs1/rs2 reads, rd write, jump),
//           writeback retirement (wb_valid, wb_wr_addr), drain_req level.
//  Outputs: stall_if / stall_id / bubble_ex on RAW/WAW hazards or while
//           draining, flush_if_id for FLUSH_CYCLES cycles after a jump issues,
//           drained (registered), busy_regs (registered scoreboard),
//           dbg_state (current sequencer state, for observation only).
//
// Issue semantics: the ID slot offers an instruction whenever id_valid=1; it
// is accepted (issues) in the same cycle only when state is RUN and it has no
// hazard. When not accepted, decode holds it (stall_id) until it is.
module hazard_control_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_REGS     = HC_NUM_REGS,
  parameter int REG_ADDR_W   = HC_REG_ADDR_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic                  id_rs1_en,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic                  id_rs2_en,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_wr_addr,
  input  logic                  id_is_jump,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_wr_addr,
  input  logic                  drain_req,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  flush_if_id,
  output logic                  drained,
  output logic [NUM_REGS-1:0]   busy_regs,
  output hc_state_e             dbg_state
);

  localparam logic [HC_FLUSH_CNT_W-1:0] FLUSH_LOAD = HC_FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  hc_state_e                 state_q;
  hc_state_e                 state_d;
  logic [HC_FLUSH_CNT_W-1:0] cnt_q;
  logic [HC_FLUSH_CNT_W-1:0] cnt_d;
  logic                      drained_q;
  logic                      drained_d;

  logic [NUM_REGS-1:0] busy_eff;
  logic                hazard;
  logic                issue;
  logic                set_en;
  logic                stall;

  reg_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (set_en),
    .set_addr (id_wr_addr),
    .clr_en   (wb_valid),
    .clr_addr (wb_wr_addr),
    .busy     (busy_regs),
    .busy_eff (busy_eff)
  );

  // Hazard and issue are purely combinational so a stall costs no extra cycle.
  always_comb begin
    hazard = id_valid & ((id_rs1_en & busy_eff[id_rs1_addr])
                       | (id_rs2_en & busy_eff[id_rs2_addr])
                       | (id_wr_en  & busy_eff[id_wr_addr]));
    issue  = id_valid & ~hazard & (state_q == HC_RUN);
    // FLUSH and DRAIN never issue, so nothing is scoreboarded there.
    set_en = issue & id_wr_en;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drained_d = 1'b0;
    stall     = 1'b0;
    case (state_q)
      HC_RUN: begin
        stall = hazard;
        // A jump issuing this cycle beats a simultaneous drain request.
        if (issue && id_is_jump) begin
          state_d = HC_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else if (drain_req) begin
          state_d = HC_DRAIN;
        end
      end
      HC_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = drain_req ? HC_DRAIN : HC_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HC_DRAIN: begin
        stall = 1'b1;
        if (drain_req) begin
          drained_d = (busy_eff == '0);
        end else begin
          state_d = HC_RUN;
        end
      end
      default: begin
        state_d = HC_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HC_RUN;
      cnt_q     <= '0;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drained_q <= drained_d;
    end
  end

  // Gating with reset_n keeps the control outputs quiet during reset even
  // though ID inputs may still be toggling.
  assign stall_if    = reset_n & stall;
  assign stall_id    = reset_n & stall;
  assign bubble_ex   = reset_n & stall;
  assign flush_if_id = reset_n & (state_q == HC_FLUSH);
  assign drained     = drained_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;
  import pipeline_ctrl_pkg::*;

  localparam int FLUSH_CYCLES = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        id_valid, id_rs1_en, id_rs2_en, id_wr_en, id_is_jump;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_wr_addr;
  logic        wb_valid;
  logic [4:0]  wb_wr_addr;
  logic        drain_req;
  logic        stall_if, stall_id, bubble_ex, flush_if_id, drained;
  logic [31:0] busy_regs;
  hc_state_e   dbg_state;

  hazard_control_unit #(
    .NUM_REGS     (32),
    .REG_ADDR_W   (5),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .id_valid    (id_valid),
    .id_rs1_en   (id_rs1_en),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_en   (id_rs2_en),
    .id_rs2_addr (id_rs2_addr),
    .id_wr_en    (id_wr_en),
    .id_wr_addr  (id_wr_addr),
    .id_is_jump  (id_is_jump),
    .wb_valid    (wb_valid),
    .wb_wr_addr  (wb_wr_addr),
    .drain_req   (drain_req),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .bubble_ex   (bubble_ex),
    .flush_if_id (flush_if_id),
    .drained     (drained),
    .busy_regs   (busy_regs),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard / counters ----------------
  int total = 0;
  int bad = 0;
  int cycle = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cycle, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending writes kept as a set of register numbers (bit mask); pipeline mode
  // kept as "flush cycles still owed" plus a draining flag.
  logic [31:0] m_busy;
  int          m_flush_left;
  bit          m_draining;
  bit          m_drained;
  logic [31:0] exp_q[$];

  task automatic model_reset();
    m_busy = 0;
    m_flush_left = 0;
    m_draining = 0;
    m_drained = 0;
  endtask

  function automatic logic [31:0] eff_busy();
    logic [31:0] b;
    b = m_busy;
    if (wb_valid) b = b & ~(32'd1 << wb_wr_addr);
    b[0] = 1'b0;
    return b;
  endfunction

  function automatic bit model_hazard();
    logic [31:0] b;
    b = eff_busy();
    return id_valid && ((id_rs1_en && b[id_rs1_addr]) ||
                        (id_rs2_en && b[id_rs2_addr]) ||
                        (id_wr_en  && b[id_wr_addr]));
  endfunction

  // Compare all outputs against the model for the inputs currently applied.
  task automatic model_check();
    bit exp_stall;
    if (m_draining) exp_stall = 1;
    else if (m_flush_left > 0) exp_stall = 0;
    else exp_stall = model_hazard();
    exp_q.push_back({29'd0, exp_stall, (m_flush_left > 0), m_drained});
    exp_q.push_back(m_busy);
    begin
      logic [31:0] e0, e1;
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      chk("ctl", {29'd0, stall_if, flush_if_id, drained}, e0);
      chk("stall_id", {31'd0, stall_id}, {31'd0, e0[2]});
      chk("bubble_ex", {31'd0, bubble_ex}, {31'd0, e0[2]});
      chk("busy_regs", busy_regs, e1);
    end
  endtask

  task automatic model_update();
    logic [31:0] b;
    bit haz, iss;
    b = eff_busy();
    haz = model_hazard();
    iss = id_valid && !haz && m_flush_left == 0 && !m_draining;
    if (iss && id_wr_en && id_wr_addr != 0) b = b | (32'd1 << id_wr_addr);
    if (m_flush_left > 0) begin
      m_drained = 0;
      m_flush_left--;
      if (m_flush_left == 0 && drain_req) m_draining = 1;
    end else if (m_draining) begin
      if (!drain_req) begin
        m_draining = 0;
        m_drained = 0;
      end else begin
        m_drained = (eff_busy() == 0);
      end
    end else begin
      m_drained = 0;
      if (iss && id_is_jump) m_flush_left = FLUSH_CYCLES;
      else if (drain_req) m_draining = 1;
    end
    m_busy = b;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    id_valid = 0; id_rs1_en = 0; id_rs2_en = 0; id_wr_en = 0; id_is_jump = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_wr_addr = 0;
    wb_valid = 0; wb_wr_addr = 0; drain_req = 0;
  endtask

  // Inputs are set just after a negedge; check, clock, land on next negedge.
  task automatic tick();
    #2;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cycle++;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    idle();
    id_valid = 1; id_wr_en = 1; id_wr_addr = rd;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_reset();
    idle();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    bit       v;
    bit       r1e; bit [4:0] r1;
    bit       r2e; bit [4:0] r2;
    bit       we;  bit [4:0] rd;
    bit       wbv; bit [4:0] wba;
    bit       exp_stall;
  } vec_t;

  vec_t vt[12];

  initial begin
    // Scoreboard holds x5 and x12 while these are applied.
    vt[0]  = '{1, 1, 5,  0, 0,  0, 0,  0, 0,  1};
    vt[1]  = '{1, 0, 5,  0, 0,  0, 0,  0, 0,  0};
    vt[2]  = '{1, 0, 0,  1, 12, 0, 0,  0, 0,  1};
    vt[3]  = '{1, 0, 0,  0, 0,  1, 12, 0, 0,  1};
    vt[4]  = '{1, 1, 5,  0, 0,  0, 0,  1, 5,  0};
    vt[5]  = '{1, 1, 5,  1, 12, 0, 0,  1, 5,  1};
    vt[6]  = '{0, 1, 5,  1, 12, 1, 5,  0, 0,  0};
    vt[7]  = '{1, 1, 0,  1, 0,  1, 0,  0, 0,  0};
    vt[8]  = '{1, 1, 6,  1, 13, 1, 4,  0, 0,  0};
    vt[9]  = '{1, 0, 0,  0, 0,  1, 5,  1, 12, 1};
    vt[10] = '{1, 0, 0,  1, 12, 0, 0,  1, 12, 0};
    vt[11] = '{1, 1, 31, 0, 0,  0, 0,  0, 0,  0};
  end

  // ---------------- main test ----------------
  initial begin
    idle();
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_stall", {31'd0, stall_if}, 32'd0);
    chk("reset_flush", {31'd0, flush_if_id}, 32'd0);
    chk("reset_drained", {31'd0, drained}, 32'd0);
    chk("reset_busy", busy_regs, 32'd0);
    do_reset();

    // --- table: combinational hazard decode against busy = {x5, x12}
    issue_wr(5);
    issue_wr(12);
    idle();
    for (int i = 0; i < 12; i++) begin
      id_valid = vt[i].v;
      id_rs1_en = vt[i].r1e; id_rs1_addr = vt[i].r1;
      id_rs2_en = vt[i].r2e; id_rs2_addr = vt[i].r2;
      id_wr_en = vt[i].we;   id_wr_addr = vt[i].rd;
      wb_valid = vt[i].wbv;  wb_wr_addr = vt[i].wba;
      #1;
      chk($sformatf("vec%0d_stall", i), {31'd0, stall_if}, {31'd0, vt[i].exp_stall});
      chk($sformatf("vec%0d_bubble", i), {31'd0, bubble_ex}, {31'd0, vt[i].exp_stall});
      idle();
      tick();
    end
    chk("vec_busy_kept", busy_regs, 32'h0000_1020);

    // --- RAW on x5, released by same-cycle writeback
    do_reset();
    issue_wr(5);
    idle();
    id_valid = 1; id_rs1_en = 1; id_rs1_addr = 5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("raw_stall", {29'd0, stall_if, stall_id, bubble_ex}, 32'd7);
      tick();
    end
    wb_valid = 1; wb_wr_addr = 5;
    #1;
    chk("raw_release", {29'd0, stall_if, stall_id, bubble_ex}, 32'd0);
    tick();
    idle();
    #1;
    chk("raw_busy5_clear", {31'd0, busy_regs[5]}, 32'd0);
    tick();

    // --- x0 never tracked
    issue_wr(0);
    id_valid = 1; id_rs1_en = 1; id_rs2_en = 1;
    #1;
    chk("x0_stall", {31'd0, stall_if}, 32'd0);
    chk("x0_busy", busy_regs, 32'd0);
    tick();

    // --- jump flush window, write during flush not tracked
    idle();
    id_valid = 1; id_is_jump = 1;
    #1;
    chk("jmp_T_flush", {31'd0, flush_if_id}, 32'd0);
    tick();
    idle();
    id_valid = 1; id_wr_en = 1; id_wr_addr = 9;
    #1;
    chk("jmp_T1_flush", {31'd0, flush_if_id}, 32'd1);
    chk("jmp_T1_stall", {31'd0, stall_if}, 32'd0);
    tick();
    #1;
    chk("jmp_T2_flush", {31'd0, flush_if_id}, 32'd1);
    tick();
    idle();
    #1;
    chk("jmp_T3_flush", {31'd0, flush_if_id}, 32'd0);
    chk("jmp_busy9", {31'd0, busy_regs[9]}, 32'd0);
    tick();

    // --- same-cycle clear and re-set of x7
    issue_wr(7);
    id_valid = 1; id_wr_en = 1; id_wr_addr = 7;
    wb_valid = 1; wb_wr_addr = 7;
    #1;
    chk("waw7_stall", {31'd0, stall_if}, 32'd0);
    tick();
    idle();
    #1;
    chk("waw7_busy", {31'd0, busy_regs[7]}, 32'd1);
    wb_valid = 1; wb_wr_addr = 7;
    tick();

    // --- drain with x3, x4 pending
    issue_wr(3);
    issue_wr(4);
    idle();
    drain_req = 1;
    tick();
    #1;
    chk("drn_stall", {31'd0, stall_if}, 32'd1);
    chk("drn_not_yet", {31'd0, drained}, 32'd0);
    wb_valid = 1; wb_wr_addr = 3;
    tick();
    wb_wr_addr = 4;
    #1;
    chk("drn_wait", {31'd0, drained}, 32'd0);
    tick();
    wb_valid = 0;
    #1;
    chk("drn_done", {31'd0, drained}, 32'd1);
    drain_req = 0;
    tick();
    #1;
    chk("drn_exit_drained", {31'd0, drained}, 32'd0);
    chk("drn_exit_state", {30'd0, dbg_state}, {30'd0, HC_RUN});
    chk("drn_exit_stall", {31'd0, stall_if}, 32'd0);
    tick();

    // --- reset in the middle of a flush
    issue_wr(3);
    issue_wr(4);
    idle();
    id_valid = 1; id_is_jump = 1;
    tick();
    idle();
    #1;
    chk("rst_pre_flush", {31'd0, flush_if_id}, 32'd1);
    chk("rst_pre_busy", busy_regs, 32'h18);
    id_valid = 1; id_rs1_en = 1; id_rs1_addr = 3;
    reset_n = 0;
    model_reset();
    #1;
    chk("rst_outputs", {27'd0, stall_if, stall_id, bubble_ex, flush_if_id, drained}, 32'd0);
    chk("rst_busy", busy_regs, 32'd0);
    @(negedge clk);
    reset_n = 1;
    idle();
    #1;
    chk("rst_state", {30'd0, dbg_state}, {30'd0, HC_RUN});
    chk("rst_flush_after", {31'd0, flush_if_id}, 32'd0);
    tick();

    // --- randomized traffic against the model
    begin
      bit drn;
      drn = 0;
      for (int i = 0; i < 1500; i++) begin
        idle();
        id_valid    = ($urandom_range(0, 3) != 0);
        id_rs1_en   = 1'($urandom_range(0, 1));
        id_rs1_addr = 5'($urandom_range(0, 7));
        id_rs2_en   = 1'($urandom_range(0, 1));
        id_rs2_addr = 5'($urandom_range(0, 7));
        id_wr_en    = 1'($urandom_range(0, 1));
        id_wr_addr  = 5'($urandom_range(0, 7));
        id_is_jump  = ($urandom_range(0, 15) == 0);
        wb_valid    = 1'($urandom_range(0, 1));
        wb_wr_addr  = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 24) == 0) drn = !drn;
        drain_req = drn;
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout cycle=%0d actual=running expected=finished", cycle);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
